// File: rtl/demux8_sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel demultiplexer.
package demux_pkg;
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int WIDTH_DEF = 8;

    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/demux8_sipo_if.sv
// Serial-in / parallel-out bus: upstream bit stream plus downstream word handshake.
interface demux8_sipo_if #(
    parameter int WIDTH = demux_pkg::WIDTH_DEF
);
    import demux_pkg::*;
    localparam int IDX_W = idx_w(WIDTH);

    logic             en;
    logic             din;
    logic             din_valid;
    logic             out_ready;
    logic             ovf_clr;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             overflow;

    modport master (
        output en, din, din_valid, out_ready, ovf_clr,
        input  y, y_valid, idx, busy, overflow
    );

    modport slave (
        input  en, din, din_valid, out_ready, ovf_clr,
        output y, y_valid, idx, busy, overflow
    );
endinterface

// File: rtl/demux8_sipo_bit_idx_counter.sv
// Bit-position counter: sync clear beats increment; wraps naturally at WIDTH (power of 2).
module bit_idx_counter
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             tc_o
);
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i)      idx_d = '0;
        else if (inc_i) idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

    assign idx_o = idx_q;
    assign tc_o  = (idx_q == IDX_W'(WIDTH - 1));
endmodule

// File: rtl/demux8_sipo.sv
// Serial-to-parallel 1:WIDTH demux: bit collection FSM, one-deep holding register, sticky overflow.
module demux8_sipo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    demux8_sipo_if.slave      bus
);
    localparam int IDX_W = idx_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] coll_q, coll_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] word_new;
    logic [IDX_W-1:0] idx;
    logic             tc, accept, complete, consume;

    assign accept   = bus.en && bus.din_valid;
    assign complete = accept && tc;
    assign consume  = y_valid_q && bus.out_ready;

    bit_idx_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!bus.en),
        .inc_i (accept),
        .idx_o (idx),
        .tc_o  (tc)
    );

    // Word as it stands including this cycle's bit; only used when accepting.
    always_comb begin
        word_new      = coll_q;
        word_new[idx] = bus.din;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !complete) state_d = COLLECT;
            COLLECT: if (complete || !bus.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coll_d = coll_q;
        if (!bus.en || complete) coll_d = '0;
        else if (accept)         coll_d = word_new;
    end

    // A completed word lands only if the holding slot is free or draining this cycle.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        ovf_d     = ovf_q;
        if (consume) y_valid_d = 1'b0;
        if (bus.ovf_clr) ovf_d = 1'b0;
        if (complete) begin
            if (!y_valid_q || bus.out_ready) begin
                y_d       = word_new;
                y_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            coll_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            coll_q    <= coll_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.idx      = idx;
    assign bus.busy     = (state_q == COLLECT);
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_demux8_sipo.sv
// Self-checking bench: directed word table, hand corner sequences and random traffic vs a reference model.
module tb_demux8_sipo;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux8_sipo_if #(.WIDTH(W)) bus ();

    demux8_sipo #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bit count, accumulated value, held word, flags.
    int m_pos, m_acc, m_y, m_yv, m_ovf;

    typedef struct {
        logic [7:0] word;
        int         gap_at;
        int         gap_len;
        logic       ordy;
        logic [7:0] exp_y;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        int acc, comp;
        if (!rst_n) begin
            m_pos = 0; m_acc = 0; m_y = 0; m_yv = 0; m_ovf = 0;
            return;
        end
        acc  = (bus.en && bus.din_valid) ? 1 : 0;
        comp = (acc && m_pos == W - 1) ? 1 : 0;
        if (bus.ovf_clr) m_ovf = 0;
        if (comp) begin
            if (!m_yv || bus.out_ready) begin
                m_y  = m_acc + (int'(bus.din) << m_pos);
                m_yv = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_yv && bus.out_ready) begin
            m_yv = 0;
        end
        if (!bus.en) begin
            m_pos = 0; m_acc = 0;
        end else if (comp) begin
            m_pos = 0; m_acc = 0;
        end else if (acc) begin
            m_acc = m_acc + (int'(bus.din) << m_pos);
            m_pos = m_pos + 1;
        end
    endtask

    // Apply current inputs for one clock, then compare every output with the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("y",        int'(bus.y),        m_y);
        chk("y_valid",  int'(bus.y_valid),  m_yv);
        chk("idx",      int'(bus.idx),      m_pos);
        chk("busy",     int'(bus.busy),     (m_pos != 0) ? 1 : 0);
        chk("overflow", int'(bus.overflow), m_ovf);
    endtask

    task automatic set_in(input logic en, input logic din, input logic dv,
                          input logic ordy, input logic clr);
        bus.en = en; bus.din = din; bus.din_valid = dv;
        bus.out_ready = ordy; bus.ovf_clr = clr;
    endtask

    task automatic feed(input logic [7:0] w, input int gap_at, input int gap_len,
                        input logic ordy_body, input logic ordy_last);
        for (int b = 0; b < W; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    set_in(1'b1, 1'b1, 1'b0, ordy_body, 1'b0);
                    step();
                    chk("gap_idx", int'(bus.idx), gap_at);
                    chk("gap_busy", int'(bus.busy), 1);
                end
            end
            set_in(1'b1, w[b], 1'b1, (b == W - 1) ? ordy_last : ordy_body, 1'b0);
            step();
        end
    endtask

    task automatic drain();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("drained", int'(bus.y_valid), 0);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{word: 8'hA5, gap_at: -1, gap_len: 0, ordy: 1'b1, exp_y: 8'hA5};
        vecs[1] = '{word: 8'h3C, gap_at: 4,  gap_len: 3, ordy: 1'b1, exp_y: 8'h3C};
        vecs[2] = '{word: 8'h81, gap_at: 1,  gap_len: 2, ordy: 1'b0, exp_y: 8'h81};
        vecs[3] = '{word: 8'hFE, gap_at: 7,  gap_len: 1, ordy: 1'b1, exp_y: 8'hFE};

        // Reset with din_valid asserted
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("rst_y", int'(bus.y), 0);
        chk("rst_yv", int'(bus.y_valid), 0);
        chk("rst_idx", int'(bus.idx), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            feed(vecs[i].word, vecs[i].gap_at, vecs[i].gap_len, vecs[i].ordy, vecs[i].ordy);
            chk("tbl_y", int'(bus.y), int'(vecs[i].exp_y));
            chk("tbl_yv", int'(bus.y_valid), 1);
            chk("tbl_idx", int'(bus.idx), 0);
            chk("tbl_busy", int'(bus.busy), 0);
            drain();
        end

        // Abort a partial word of ones, then a clean 0x01
        for (int b = 0; b < 5; b++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("abort_idx", int'(bus.idx), 0);
        chk("abort_busy", int'(bus.busy), 0);
        feed(8'h01, -1, 0, 1'b1, 1'b1);
        chk("abort_y", int'(bus.y), 8'h01);
        drain();

        // Two words under stall: second is dropped
        feed(8'h12, -1, 0, 1'b0, 1'b0);
        feed(8'h34, -1, 0, 1'b0, 1'b0);
        chk("stall_y", int'(bus.y), 8'h12);
        chk("stall_ovf", int'(bus.overflow), 1);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("stall_yv", int'(bus.y_valid), 0);
        chk("stall_y_keep", int'(bus.y), 8'h12);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("ovf_clr", int'(bus.overflow), 0);

        // Drop coinciding with ovf_clr: set wins
        feed(8'h77, -1, 0, 1'b0, 1'b0);
        for (int b = 0; b < W; b++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b0, (b == W - 1));
            step();
        end
        chk("setwins_ovf", int'(bus.overflow), 1);
        chk("setwins_y", int'(bus.y), 8'h77);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step();

        // Pending 0x55 consumed in the cycle 0xAA completes
        feed(8'h55, -1, 0, 1'b0, 1'b0);
        feed(8'hAA, -1, 0, 1'b0, 1'b1);
        chk("simul_y", int'(bus.y), 8'hAA);
        chk("simul_yv", int'(bus.y_valid), 1);
        chk("simul_ovf", int'(bus.overflow), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            set_in($urandom_range(0, 15) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
